// File: rtl/ysyx_25050141_wb_arbiter.sv
// Write-back arbiter: accepts ALU/LSU results, queues them in acceptance order and
// drives the single register-file write port at one write per cycle.
module ysyx_25050141_wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int WIDTH  = 5,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [WIDTH-1:0]          alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [WIDTH-1:0]          lsu_rd,
    input  logic [XLEN-1:0]           lsu_data,
    output logic                      wen,
    output logic [WIDTH-1:0]          waddr,
    output logic [XLEN-1:0]           wdata,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {PRIO_ALU = 1'b0, PRIO_LSU = 1'b1} prio_e;

    logic [WIDTH-1:0] rd_mem   [QDEPTH];
    logic [XLEN-1:0]  data_mem [QDEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    prio_e            prio_q, prio_d;
    logic             wen_q, wen_d;
    logic [WIDTH-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;

    logic [CW-1:0]    free;
    logic             alu_fire, lsu_fire;
    logic             alu_enq, lsu_enq, dual_enq;
    logic             slot0_lsu;
    logic [WIDTH-1:0] slot0_rd, slot1_rd;
    logic [XLEN-1:0]  slot0_data, slot1_data;
    logic [CW-1:0]    enq_cnt;
    logic             pop;

    // Readies derive from registered occupancy only; a same-cycle pop is not credited.
    always_comb begin
        free      = CW'(QDEPTH) - count_q;
        alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && (prio_q == PRIO_ALU));
        lsu_ready = (free >= CW'(2)) || ((free == CW'(1)) && (prio_q == PRIO_LSU));
    end

    assign alu_fire = alu_valid && alu_ready;
    assign lsu_fire = lsu_valid && lsu_ready;
    assign alu_enq  = alu_fire && (alu_rd != '0);
    assign lsu_enq  = lsu_fire && (lsu_rd != '0);
    assign dual_enq = alu_enq && lsu_enq;
    assign enq_cnt  = CW'(alu_enq) + CW'(lsu_enq);
    assign pop      = (count_q != '0);

    // On a double enqueue the prioritised source takes the lower slot.
    always_comb begin
        slot0_lsu  = dual_enq ? (prio_q == PRIO_LSU) : lsu_enq;
        slot0_rd   = slot0_lsu ? lsu_rd   : alu_rd;
        slot0_data = slot0_lsu ? lsu_data : alu_data;
        slot1_rd   = slot0_lsu ? alu_rd   : lsu_rd;
        slot1_data = slot0_lsu ? alu_data : lsu_data;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(enq_cnt);
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + enq_cnt - CW'(pop);
        prio_d   = prio_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            wen_d    = 1'b1;
            waddr_d  = rd_mem[rd_ptr_q];
            wdata_d  = data_mem[rd_ptr_q];
        end
        if (((prio_q == PRIO_ALU) && alu_fire) || ((prio_q == PRIO_LSU) && lsu_fire)) begin
            prio_d = (prio_q == PRIO_ALU) ? PRIO_LSU : PRIO_ALU;
        end
    end

    // Storage carries no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (enq_cnt != '0) begin
            rd_mem[wr_ptr_q]   <= slot0_rd;
            data_mem[wr_ptr_q] <= slot0_data;
        end
        if (dual_enq) begin
            rd_mem[wr_ptr_q + PW'(1)]   <= slot1_rd;
            data_mem[wr_ptr_q + PW'(1)] <= slot1_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= PRIO_ALU;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign count = count_q;

endmodule

// File: tb/tb_ysyx_25050141_wb_arbiter.sv
// Directed bench for the write-back arbiter; a behavioural queue model predicts
// readies, occupancy and the write stream cycle by cycle.
module tb_ysyx_25050141_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, waddr;
    logic [31:0] alu_data, lsu_data, wdata;
    logic        wen;
    logic [2:0]  count;

    ysyx_25050141_wb_arbiter #(.XLEN(32), .WIDTH(5), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wen(wen), .waddr(waddr), .wdata(wdata), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_prio;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    int          n_checks;
    int          n_pass;
    int          wen_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic m_ardy();
        int fr = 4 - mq.size();
        return (fr >= 2) || ((fr == 1) && (m_prio == 1'b0));
    endfunction

    function automatic logic m_lrdy();
        int fr = 4 - mq.size();
        return (fr >= 2) || ((fr == 1) && (m_prio == 1'b1));
    endfunction

    task automatic model_clear();
        mq.delete();
        m_prio    = 1'b0;
        exp_wen   = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        ent_t e;
        e.rd   = rd;
        e.data = data;
        if (rd != 5'd0) mq.push_back(e);
    endtask

    task automatic check_outputs();
        if (wen === 1'b1) wen_seen++;
        check("wen", 64'(wen), 64'(exp_wen));
        check("waddr", 64'(waddr), 64'(exp_waddr));
        check("wdata", 64'(wdata), 64'(exp_wdata));
        check("count", 64'(count), 64'(mq.size()));
        check("alu_ready", 64'(alu_ready), 64'(m_ardy()));
        check("lsu_ready", 64'(lsu_ready), 64'(m_lrdy()));
    endtask

    // Called at a falling edge: check, drive, advance model across one rising edge.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         output logic af, output logic lf);
        ent_t e;
        check_outputs();
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        af = av && m_ardy();
        lf = lv && m_lrdy();
        @(posedge clk);
        if (mq.size() != 0) begin
            e = mq.pop_front();
            exp_wen   = 1'b1;
            exp_waddr = e.rd;
            exp_wdata = e.data;
        end else begin
            exp_wen = 1'b0;
        end
        if (af && lf) begin
            if (m_prio == 1'b0) begin push(ard, ad); push(lrd, ld); end
            else begin push(lrd, ld); push(ard, ad); end
        end else if (af) begin
            push(ard, ad);
        end else if (lf) begin
            push(lrd, ld);
        end
        if ((m_prio == 1'b0 && af) || (m_prio == 1'b1 && lf)) m_prio = ~m_prio;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic af, lf;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, af, lf);
    endtask

    initial begin
        logic af, lf;
        int ai, li;
        n_checks = 0;
        n_pass   = 0;
        wen_seen = 0;
        model_clear();

        // Reset held with both sources presenting results.
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        rst = 1'b1;
        idle(2);

        // Single ALU write.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, af, lf);
        idle(4);

        // Restore ALU priority, then dual fire; second dual fire shows LSU priority.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, af, lf);
        idle(3);
        cycle(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, af, lf);
        idle(4);
        cycle(1'b1, 5'd3, 32'd33, 1'b1, 5'd4, 32'd44, af, lf);
        idle(4);

        // Backpressure: both sources always valid, each holds its value until it fires.
        wen_seen = 0;
        ai = 0;
        li = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 5'((ai % 31) + 1), 32'hA000_0000 + 32'(ai),
                  1'b1, 5'((li % 31) + 1), 32'hB000_0000 + 32'(li), af, lf);
            if (af) ai++;
            if (lf) li++;
        end
        idle(6);
        check("bp_writes", 64'(wen_seen), 64'd12);

        // Result to x0 is accepted but never written.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, af, lf);
        idle(3);
        cycle(1'b1, 5'd9, 32'h9999, 1'b1, 5'd0, 32'h1234, af, lf);
        idle(3);

        // Mid-operation flush with three queued entries.
        cycle(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB, af, lf);
        cycle(1'b1, 5'd12, 32'hCCCC, 1'b1, 5'd13, 32'hDDDD, af, lf);
        check_outputs();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check("flush_wen", 64'(wen), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wen_seen = 0;
        idle(5);
        check("flush_no_write", 64'(wen_seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
